// File: rtl/spi_ram_ctrl.sv
// Command decoder and single-port RAM behind an SPI slave: executes 10-bit
// {opcode, payload} words and returns read bytes on a level-held tx_data/tx_valid.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8,
    parameter int AUTO_INC  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE-1:0] rd_addr
);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_e;

    localparam logic [ADDR_SIZE:0] DEPTH_C = MEM_DEPTH[ADDR_SIZE:0];

    logic [7:0]           mem_r [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr_r;
    logic [ADDR_SIZE-1:0] rd_addr_r;
    logic [7:0]           tx_data_r;
    logic                 tx_valid_r;

    opcode_e              opcode_s;
    logic [ADDR_SIZE-1:0] wr_addr_nxt_s;
    logic [ADDR_SIZE-1:0] rd_addr_nxt_s;
    logic                 mem_we_s;
    logic                 rd_en_s;
    logic                 wr_in_range_s;
    logic                 rd_in_range_s;

    // Post-increment modulo MEM_DEPTH; anything at or past the last word wraps to 0.
    function automatic logic [ADDR_SIZE-1:0] inc_addr(input logic [ADDR_SIZE-1:0] addr);
        logic [ADDR_SIZE:0] next_v;
        next_v = {1'b0, addr} + {{ADDR_SIZE{1'b0}}, 1'b1};
        if (next_v >= DEPTH_C) begin
            inc_addr = {ADDR_SIZE{1'b0}};
        end else begin
            inc_addr = next_v[ADDR_SIZE-1:0];
        end
    endfunction

    assign opcode_s      = opcode_e'(rx_data[9:8]);
    assign wr_in_range_s = ({1'b0, wr_addr_r} < DEPTH_C);
    assign rd_in_range_s = ({1'b0, rd_addr_r} < DEPTH_C);

    // Command decode: next addresses and array read/write enables.
    always_comb begin
        wr_addr_nxt_s = wr_addr_r;
        rd_addr_nxt_s = rd_addr_r;
        mem_we_s      = 1'b0;
        rd_en_s       = 1'b0;
        if (rx_valid && !reset) begin
            case (opcode_s)
                OP_WR_ADDR: wr_addr_nxt_s = rx_data[ADDR_SIZE-1:0];
                OP_WR_DATA: begin
                    mem_we_s = wr_in_range_s;
                    if (AUTO_INC != 0) begin
                        wr_addr_nxt_s = inc_addr(wr_addr_r);
                    end else begin
                        wr_addr_nxt_s = wr_addr_r;
                    end
                end
                OP_RD_ADDR: rd_addr_nxt_s = rx_data[ADDR_SIZE-1:0];
                OP_RD_DATA: begin
                    rd_en_s = 1'b1;
                    if (AUTO_INC != 0) begin
                        rd_addr_nxt_s = inc_addr(rd_addr_r);
                    end else begin
                        rd_addr_nxt_s = rd_addr_r;
                    end
                end
                default: begin
                    wr_addr_nxt_s = wr_addr_r;
                    rd_addr_nxt_s = rd_addr_r;
                end
            endcase
        end else begin
            mem_we_s = 1'b0;
            rd_en_s  = 1'b0;
        end
    end

    // Storage array; deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_addr_r] <= rx_data[7:0];
        end
    end

    // Address registers and registered read port with level-held tx_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_addr_r  <= {ADDR_SIZE{1'b0}};
            rd_addr_r  <= {ADDR_SIZE{1'b0}};
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
        end else begin
            wr_addr_r <= wr_addr_nxt_s;
            rd_addr_r <= rd_addr_nxt_s;
            if (rd_en_s) begin
                tx_valid_r <= 1'b1;
                tx_data_r  <= rd_in_range_s ? mem_r[rd_addr_r] : 8'h00;
            end else if (rx_valid) begin
                tx_valid_r <= 1'b0;
            end
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign wr_addr  = wr_addr_r;
    assign rd_addr  = rd_addr_r;

endmodule
